// File: rtl/font_stream_ctrl.sv
// font_stream_ctrl: renders a buffered text line into a column-byte stream by
// walking the glyph ROM 8 columns per character, with valid/ready output.
module font_stream_ctrl #(
  parameter int MAX_CHARS = 16,
  parameter int IDX_W     = 4,
  parameter int ROM_AW    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [6:0]        wr_char,
  input  logic              start,
  input  logic [IDX_W:0]    len,
  output logic              busy,
  output logic              done,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t           state, state_nx;
  logic [6:0]       line_buf [MAX_CHARS];
  logic [IDX_W-1:0] idx, idx_nx, rd_idx;
  logic [2:0]       col, col_nx, rd_col;
  logic [IDX_W:0]   len_q, len_nx, len_clamp;
  logic             done_q, done_nx;
  logic             is_last;

  assign len_clamp = (len > (IDX_W+1)'(MAX_CHARS)) ? (IDX_W+1)'(MAX_CHARS) : len;
  assign is_last   = (state == STREAM) && ((IDX_W+1)'(idx) == len_q - (IDX_W+1)'(1))
                     && (col == 3'd7);

  assign busy      = (state != IDLE);
  assign out_valid = (state == STREAM);
  assign out_last  = is_last;
  assign out_data  = rom_data;
  assign done      = done_q;
  // Address follows the pointer the ROM read is issued for (next byte on a handshake)
  assign rom_addr  = ROM_AW'({line_buf[rd_idx], rd_col});

  // Line buffer: host writes only land while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) line_buf[wr_addr] <= wr_char;
  end

  // State, pointers, latched length and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      col    <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      col    <= col_nx;
      len_q  <= len_nx;
      done_q <= done_nx;
    end
  end

  // Next-state, pointer advance and ROM read issue
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    col_nx   = col;
    len_nx   = len_q;
    done_nx  = 1'b0;
    rom_en   = 1'b0;
    rd_idx   = idx;
    rd_col   = col;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamp == '0) begin
            done_nx = 1'b1;
          end else begin
            len_nx   = len_clamp;
            idx_nx   = '0;
            col_nx   = '0;
            rd_idx   = '0;
            rd_col   = '0;
            state_nx = FETCH;
          end
        end
      end
      FETCH: begin
        rom_en   = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        if (out_ready) begin
          if (is_last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            col_nx = col + 3'd1;
            if (col == 3'd7) idx_nx = idx + 1'b1;
            // Prefetch the next byte so the stream keeps one byte per cycle
            rom_en = 1'b1;
            rd_idx = idx_nx;
            rd_col = col_nx;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_font_stream_ctrl.sv
// Scoreboard bench for font_stream_ctrl: stimulus pushes expected addresses,
// bytes and done timing; a negedge monitor pops and compares.
module tb_font_stream_ctrl;
  logic        clk = 0;
  logic        rst, wr_en, start, rom_en, busy, done, out_valid, out_ready, out_last;
  logic [3:0]  wr_addr;
  logic [6:0]  wr_char;
  logic [4:0]  len;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data, out_data;

  font_stream_ctrl #(.MAX_CHARS(16), .IDX_W(4), .ROM_AW(11)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .start(start), .len(len), .busy(busy), .done(done), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0, n_pop = 0, rmode = 0;
  logic [6:0]  shadow [16];
  logic [7:0]  exp_data [$];
  bit          exp_last [$];
  logic [10:0] exp_addr [$];
  int          exp_done [$];
  bit          stall = 0;
  logic [7:0]  st_d;
  logic        st_l;

  // Stand-in glyph ROM: arbitrary fixed contents, registered read
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    logic [15:0] t;
    t = {5'd0, a} * 16'd40503;
    return t[15:8] ^ a[7:0];
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: all output checking, decoupled from stimulus
  initial forever begin
    @(negedge clk);
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, st_d);
        chk("stall_last", out_last, st_l);
      end
      if (!busy) chk("rom_en_idle", rom_en, 0);
      if (rom_en) begin
        if (exp_addr.size() == 0) chk("unexpected_rom_en", 1, 0);
        else chk("rom_addr", rom_addr, exp_addr.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          chk("out_data", out_data, exp_data.pop_front());
          chk("out_last", out_last, exp_last.pop_front());
          n_pop++;
        end
      end
      stall = out_valid && !out_ready;
      st_d = out_data;
      st_l = out_last;
      if (done) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          int e;
          e = exp_done.pop_front();
          if (e >= 0) chk("done_cycle", cyc, e);
          chk("bytes_left_at_done", exp_data.size(), 0);
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wr(input int slot, input logic [6:0] ch);
    wr_en = 1; wr_addr = 4'(slot); wr_char = ch;
    shadow[slot] = ch;
    tick();
    wr_en = 0;
  endtask

  // Issue start; reference model: clamp length, list every (char, column) in order
  task automatic do_start(input int n, input bit wsame, input int wslot, input logic [6:0] wch);
    int m;
    if (wsame) begin
      wr_en = 1; wr_addr = 4'(wslot); wr_char = wch; shadow[wslot] = wch;
    end
    m = (n > 16) ? 16 : n;
    for (int i = 0; i < m; i++)
      for (int c = 0; c < 8; c++) begin
        exp_addr.push_back({1'b0, shadow[i], 3'(c)});
        exp_data.push_back(rom_fn({1'b0, shadow[i], 3'(c)}));
        exp_last.push_back(i == m - 1 && c == 7);
      end
    exp_done.push_back(rmode != 0 ? -1 : (m == 0 ? cyc + 1 : cyc + 8 * m + 2));
    start = 1; len = 5'(n);
    tick();
    start = 0; wr_en = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (exp_data.size() == 0 && exp_done.size() == 0 && exp_addr.size() == 0) begin
        ok = 1; break;
      end
    end
    chk("render_completes", ok, 1);
  endtask

  initial begin
    rst = 1; start = 1; len = 5'd3; wr_en = 0; wr_addr = 0; wr_char = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) shadow[i] = 7'(i + 32);
    // Reset held with start asserted: everything stays quiet
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_valid", out_valid, 0);
      chk("rst_rom_en", rom_en, 0); chk("rst_done", done, 0);
    end
    tick(); rst = 0; start = 0;
    for (int i = 0; i < 16; i++) wr(i, shadow[i]);
    repeat (4) tick();

    // Single character, ready always high
    rmode = 0;
    wr(0, 7'h41);
    do_start(1, 0, 0, 0);
    wait_idle();

    // Three characters with throttled ready
    wr(0, 7'h30); wr(1, 7'h2E); wr(2, 7'h35);
    rmode = 1;
    do_start(3, 0, 0, 0);
    wait_idle();

    // Empty line, then over-long line clamped to 16
    rmode = 0;
    do_start(0, 0, 0, 0);
    wait_idle();
    for (int i = 0; i < 16; i++) wr(i, 7'($urandom_range(0, 127)));
    do_start(31, 0, 0, 0);
    wait_idle();

    // start and wr_en while busy are dropped; replay shows original contents
    wr(0, 7'h12); wr(1, 7'h6B);
    rmode = 1;
    do_start(2, 0, 0, 0);
    repeat (3) tick();
    wr_en = 1; wr_addr = 0; wr_char = 7'h7F; start = 1; len = 5'd5;
    tick();
    wr_en = 0; start = 0;
    wait_idle();
    rmode = 0;
    do_start(2, 0, 0, 0);
    wait_idle();

    // Write in the same cycle as start is seen by the render
    do_start(2, 1, 1, 7'h55);
    wait_idle();

    // Reset mid-render abandons the line, then a full re-render
    do_start(2, 0, 0, 0);
    for (int k = 0; k < 100 && n_pop % 16 != 5; k++) tick();
    rst = 1;
    exp_data.delete(); exp_last.delete(); exp_addr.delete(); exp_done.delete();
    tick();
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy", busy, 0);
    tick();
    do_start(2, 0, 0, 0);
    wait_idle();

    // Randomized lines
    for (int t = 0; t < 10; t++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, 15), 7'($urandom_range(0, 127)));
      rmode = $urandom_range(0, 1);
      do_start($urandom_range(0, 20), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
               7'($urandom_range(0, 127)));
      wait_idle();
    end
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end
endmodule
